// File: rtl/mem_access_queue_pkg.sv
// Shared widths, queue depth, FSM encoding and queue entry layout for the memory access queue.
// Pure declarations: no latency and no flow control of its own.
package mem_access_queue_pkg;
   localparam int DATA_W = 16;
   localparam int TAG_W  = 5;
   localparam int DEPTH  = 4;
   localparam int IDX_W  = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] addr;
      logic [TAG_W-1:0]  tag;
      logic              is_store;
      logic [DATA_W-1:0] wdata;
   } entry_t;
endpackage

// File: rtl/mem_access_queue_if.sv
// Address-stage, data-memory and completion signals of the memory access queue.
// slave is the queue's view; master is the surrounding pipeline and memory.
interface mem_access_queue_if;
   import mem_access_queue_pkg::*;

   logic              flush;
   logic              freeze_back;
   logic              valid_Addr_agu;
   logic [DATA_W-1:0] Addr_agu;
   logic [TAG_W-1:0]  tag_ROB_Result_agu;
   logic              is_store_agu;
   logic [DATA_W-1:0] data_store_agu;
   logic              full_lsq;
   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              valid_Result_mem;
   logic [TAG_W-1:0]  tag_ROB_Result_mem;
   logic [DATA_W-1:0] Result_mem;

   modport slave (
      input  flush, freeze_back, valid_Addr_agu, Addr_agu, tag_ROB_Result_agu,
             is_store_agu, data_store_agu, mem_ack, mem_rdata,
      output full_lsq, mem_req, mem_we, mem_addr, mem_wdata,
             valid_Result_mem, tag_ROB_Result_mem, Result_mem
   );

   modport master (
      output flush, freeze_back, valid_Addr_agu, Addr_agu, tag_ROB_Result_agu,
             is_store_agu, data_store_agu, mem_ack, mem_rdata,
      input  full_lsq, mem_req, mem_we, mem_addr, mem_wdata,
             valid_Result_mem, tag_ROB_Result_mem, Result_mem
   );
endinterface

// File: rtl/mem_access_queue_lsq_fifo.sv
// 4-entry in-order entry store; head is visible combinationally, push/pop take effect at the edge.
// A push while full is dropped; flush empties it in one edge.
module lsq_fifo
   import mem_access_queue_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   flush,
   input  logic   push,
   input  entry_t push_dat,
   input  logic   pop,
   output entry_t head,
   output logic   empty,
   output logic   full
);
   localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

   entry_t         slots [DEPTH];
   logic [IDX_W:0] wr_ptr;
   logic [IDX_W:0] rd_ptr;
   logic           do_push;
   logic           do_pop;

   // Top bit is the wrap flag: equal indices mean full when the wraps differ.
   assign full    = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
   assign empty   = (wr_ptr == rd_ptr);
   assign head    = slots[rd_ptr[IDX_W-1:0]];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) slots[wr_ptr[IDX_W-1:0]] <= push_dat;
   end
endmodule

// File: rtl/mem_access_queue.sv
// In-order load/store queue issuing one memory request at a time; enqueue to mem_req is 2 edges, ack to result 1 edge.
// Upstream must hold off while full_lsq; freeze_back stalls enqueue and holds the result, flush drops everything.
module mem_access_queue
   import mem_access_queue_pkg::*;
(
   input logic             clk,
   input logic             rst,
   mem_access_queue_if.slave bus
);
   state_t            state;
   state_t            state_nxt;
   entry_t            head;
   entry_t            push_dat;
   logic              empty;
   logic              full;
   logic              enq;
   logic              pop;
   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [TAG_W-1:0]  res_tag;
   logic [DATA_W-1:0] res_dat;

   assign push_dat = '{addr:     bus.Addr_agu,
                       tag:      bus.tag_ROB_Result_agu,
                       is_store: bus.is_store_agu,
                       wdata:    bus.data_store_agu};

   assign enq = bus.valid_Addr_agu && !full && !bus.flush && !bus.freeze_back;
   // An ack landing in a flush cycle is discarded along with everything else.
   assign pop = (state == REQ) && bus.mem_ack && !bus.flush;

   lsq_fifo u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (bus.flush),
      .push     (enq),
      .push_dat (push_dat),
      .pop      (pop),
      .head     (head),
      .empty    (empty),
      .full     (full)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (!empty) state_nxt = REQ;
            REQ:     if (bus.mem_ack) state_nxt = DONE;
            DONE:    if (!bus.freeze_back) state_nxt = empty ? IDLE : REQ;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state == REQ) begin
         mem_req   = 1'b1;
         mem_we    = head.is_store;
         mem_addr  = head.addr;
         mem_wdata = head.wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_tag <= '0;
         res_dat <= '0;
      end else if (bus.flush) begin
         res_tag <= '0;
         res_dat <= '0;
      end else if (pop) begin
         res_tag <= head.tag;
         res_dat <= head.is_store ? '0 : bus.mem_rdata;
      end
   end

   assign bus.full_lsq           = full;
   assign bus.mem_req            = mem_req;
   assign bus.mem_we             = mem_we;
   assign bus.mem_addr           = mem_addr;
   assign bus.mem_wdata          = mem_wdata;
   assign bus.valid_Result_mem   = (state == DONE);
   assign bus.tag_ROB_Result_mem = res_tag;
   assign bus.Result_mem         = res_dat;
endmodule

// File: tb/tb_mem_access_queue.sv
// Bench for mem_access_queue: scoreboard of expected completions plus per-scenario directed checks.
// A negedge memory responder acks after ack_delay request cycles.
module tb_mem_access_queue;
   import mem_access_queue_pkg::*;

   typedef struct {
      logic [4:0]  tag;
      logic [15:0] data;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        flush  = 1'b0;
   logic        freeze = 1'b0;
   logic        vld    = 1'b0;
   logic [15:0] addr   = '0;
   logic [4:0]  tag    = '0;
   logic        st     = 1'b0;
   logic [15:0] wdata  = '0;
   logic        ack    = 1'b0;
   logic [15:0] rdata  = '0;
   logic        prev_vld = 1'b0;

   int errors    = 0;
   int checks    = 0;
   int proto_err = 0;
   int ack_delay = 0;
   int req_cnt   = 0;

   exp_t        sb [$];
   logic [15:0] mem_model [logic [15:0]];

   mem_access_queue_if bus();

   assign bus.flush              = flush;
   assign bus.freeze_back        = freeze;
   assign bus.valid_Addr_agu     = vld;
   assign bus.Addr_agu           = addr;
   assign bus.tag_ROB_Result_agu = tag;
   assign bus.is_store_agu       = st;
   assign bus.data_store_agu     = wdata;
   assign bus.mem_ack            = ack;
   assign bus.mem_rdata          = rdata;

   mem_access_queue dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] rd_model(input logic [15:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 16'hA5A5;
   endfunction

   always @(negedge clk) begin
      if (bus.mem_req) begin
         if (req_cnt >= ack_delay) begin
            ack     = 1'b1;
            rdata   = rd_model(bus.mem_addr);
            req_cnt = 0;
         end else begin
            ack     = 1'b0;
            req_cnt = req_cnt + 1;
         end
      end else begin
         ack     = 1'b0;
         req_cnt = 0;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (bus.valid_Result_mem && !prev_vld) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got tag=%0d data=%h, required no result",
                     bus.tag_ROB_Result_mem, bus.Result_mem);
         end else begin
            e = sb.pop_front();
            if (bus.tag_ROB_Result_mem !== e.tag || bus.Result_mem !== e.data) begin
               errors++;
               $display("FAIL sb_result: got tag=%0d data=%h, required tag=%0d data=%h",
                        bus.tag_ROB_Result_mem, bus.Result_mem, e.tag, e.data);
            end
         end
      end
      prev_vld = bus.valid_Result_mem;
   end

   always @(posedge clk) begin
      if (rst && vld && bus.full_lsq) proto_err++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [15:0] a, input logic [4:0] t, input logic s,
                      input logic [15:0] d, input bit accept);
      vld   = 1'b1;
      addr  = a;
      tag   = t;
      st    = s;
      wdata = d;
      if (accept) sb.push_back('{tag: t, data: (s ? 16'h0000 : rd_model(a))});
      tick();
      vld = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((sb.size() != 0 || bus.valid_Result_mem || bus.mem_req) && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL %s_drain: timeout with %0d results outstanding, required 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) tick();
      checks++;
      if ({bus.full_lsq, bus.mem_req, bus.mem_we} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctrl: full/req/we=%b, required 000",
                  {bus.full_lsq, bus.mem_req, bus.mem_we});
      end
      checks++;
      if ({bus.mem_addr, bus.mem_wdata} !== 32'h0) begin
         errors++;
         $display("FAIL reset_bus: addr=%h wdata=%h, required 0000 0000", bus.mem_addr, bus.mem_wdata);
      end
      checks++;
      if ({bus.valid_Result_mem, bus.tag_ROB_Result_mem, bus.Result_mem} !== 22'h0) begin
         errors++;
         $display("FAIL reset_result: vld=%b tag=%0d data=%h, required 0 0 0000",
                  bus.valid_Result_mem, bus.tag_ROB_Result_mem, bus.Result_mem);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single_load();
      ack_delay = 0;
      enq(16'h0040, 5'd3, 1'b0, 16'h0000, 1'b1);
      checks++;
      if (bus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL load_req_early: mem_req=%b, required 0", bus.mem_req);
      end
      tick();
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 16'h0040}) begin
         errors++;
         $display("FAIL load_req: req=%b we=%b addr=%h, required 1 0 0040",
                  bus.mem_req, bus.mem_we, bus.mem_addr);
      end
      tick();
      checks++;
      if ({bus.valid_Result_mem, bus.tag_ROB_Result_mem, bus.Result_mem} !== {1'b1, 5'd3, 16'hBEEF}) begin
         errors++;
         $display("FAIL load_result: vld=%b tag=%0d data=%h, required 1 3 beef",
                  bus.valid_Result_mem, bus.tag_ROB_Result_mem, bus.Result_mem);
      end
      tick();
      checks++;
      if (bus.valid_Result_mem !== 1'b0) begin
         errors++;
         $display("FAIL load_pulse: vld=%b one cycle later, required 0", bus.valid_Result_mem);
      end
      drain("load");
   endtask

   task automatic test_store();
      ack_delay = 3;
      enq(16'h0010, 5'd7, 1'b1, 16'h1234, 1'b1);
      tick();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({bus.mem_req, bus.mem_we, bus.valid_Result_mem, bus.mem_addr, bus.mem_wdata} !==
             {3'b110, 16'h0010, 16'h1234}) begin
            errors++;
            $display("FAIL store_hold%0d: req=%b we=%b vld=%b addr=%h wdata=%h, required 1 1 0 0010 1234",
                     k, bus.mem_req, bus.mem_we, bus.valid_Result_mem, bus.mem_addr, bus.mem_wdata);
         end
         tick();
      end
      tick();
      checks++;
      if ({bus.valid_Result_mem, bus.tag_ROB_Result_mem, bus.Result_mem} !== {1'b1, 5'd7, 16'h0000}) begin
         errors++;
         $display("FAIL store_result: vld=%b tag=%0d data=%h, required 1 7 0000",
                  bus.valid_Result_mem, bus.tag_ROB_Result_mem, bus.Result_mem);
      end
      drain("store");
   endtask

   task automatic test_full();
      int p;
      ack_delay = 100000;
      for (int i = 0; i < 4; i++) begin
         enq(16'h0100 + 16'(i), 5'(10 + i), 1'b0, 16'h0000, 1'b1);
         checks++;
         if (bus.full_lsq !== (i == 3)) begin
            errors++;
            $display("FAIL full_after%0d: full_lsq=%b, required %0b", i + 1, bus.full_lsq, (i == 3));
         end
      end
      p = proto_err;
      enq(16'h0200, 5'd20, 1'b0, 16'h0000, 1'b0);
      checks++;
      if (proto_err - p !== 1) begin
         errors++;
         $display("FAIL full_proto: flagged %0d, required 1", proto_err - p);
      end
      checks++;
      if ({bus.full_lsq, bus.mem_addr} !== {1'b1, 16'h0100}) begin
         errors++;
         $display("FAIL full_ignore: full=%b head addr=%h, required 1 0100", bus.full_lsq, bus.mem_addr);
      end
      ack_delay = 0;
      drain("full");
   endtask

   task automatic test_back_to_back();
      ack_delay = 0;
      for (int i = 0; i < 8; i++) begin
         enq(16'h0300 + 16'(i * 4), 5'(i), i[0], 16'h5000 + 16'(i), 1'b1);
         tick();
      end
      drain("b2b");
   endtask

   task automatic test_freeze();
      ack_delay = 0;
      enq(16'h0050, 5'd9, 1'b0, 16'h0000, 1'b1);
      tick();
      tick();
      checks++;
      if ({bus.valid_Result_mem, bus.tag_ROB_Result_mem} !== {1'b1, 5'd9}) begin
         errors++;
         $display("FAIL freeze_pre: vld=%b tag=%0d, required 1 9", bus.valid_Result_mem, bus.tag_ROB_Result_mem);
      end
      freeze = 1'b1;
      vld    = 1'b1;
      addr   = 16'h0060;
      tag    = 5'd10;
      st     = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if ({bus.valid_Result_mem, bus.tag_ROB_Result_mem, bus.Result_mem} !==
             {1'b1, 5'd9, rd_model(16'h0050)}) begin
            errors++;
            $display("FAIL freeze_hold%0d: vld=%b tag=%0d data=%h, required 1 9 %h", k,
                     bus.valid_Result_mem, bus.tag_ROB_Result_mem, bus.Result_mem, rd_model(16'h0050));
         end
      end
      freeze = 1'b0;
      vld    = 1'b0;
      tick();
      tick();
      checks++;
      if ({bus.valid_Result_mem, bus.mem_req} !== 2'b00) begin
         errors++;
         $display("FAIL freeze_noenq: vld=%b req=%b, required 0 0", bus.valid_Result_mem, bus.mem_req);
      end
      drain("freeze");
   endtask

   task automatic test_flush();
      ack_delay = 100000;
      for (int i = 0; i < 3; i++) enq(16'h0400 + 16'(i), 5'(20 + i), 1'b0, 16'h0000, 1'b1);
      checks++;
      if (bus.mem_req !== 1'b1) begin
         errors++;
         $display("FAIL flush_pre: mem_req=%b, required 1", bus.mem_req);
      end
      ack_delay = 0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      sb.delete();
      checks++;
      if ({bus.mem_req, bus.valid_Result_mem, bus.full_lsq} !== 3'b000) begin
         errors++;
         $display("FAIL flush_now: req=%b vld=%b full=%b, required 000",
                  bus.mem_req, bus.valid_Result_mem, bus.full_lsq);
      end
      repeat (2) tick();
      checks++;
      if ({bus.mem_req, bus.valid_Result_mem} !== 2'b00) begin
         errors++;
         $display("FAIL flush_empty: req=%b vld=%b, required 0 0", bus.mem_req, bus.valid_Result_mem);
      end
   endtask

   task automatic test_async_reset();
      ack_delay = 100000;
      enq(16'h0070, 5'd4, 1'b1, 16'hCAFE, 1'b1);
      tick();
      checks++;
      if ({bus.mem_req, bus.mem_we} !== 2'b11) begin
         errors++;
         $display("FAIL areset_pre: req=%b we=%b, required 1 1", bus.mem_req, bus.mem_we);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.full_lsq, bus.valid_Result_mem, bus.mem_addr, bus.mem_wdata,
           bus.tag_ROB_Result_mem, bus.Result_mem} !== 57'h0) begin
         errors++;
         $display("FAIL areset_outputs: req=%b we=%b full=%b vld=%b addr=%h wdata=%h tag=%0d data=%h, required all 0",
                  bus.mem_req, bus.mem_we, bus.full_lsq, bus.valid_Result_mem, bus.mem_addr,
                  bus.mem_wdata, bus.tag_ROB_Result_mem, bus.Result_mem);
      end
      rst = 1'b1;
      sb.delete();
      ack_delay = 0;
      repeat (2) tick();
      checks++;
      if (bus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL areset_cleared: mem_req=%b, required 0", bus.mem_req);
      end
   endtask

   initial begin
      mem_model[16'h0040] = 16'hBEEF;
      test_reset();
      test_single_load();
      test_store();
      test_full();
      test_back_to_back();
      test_freeze();
      test_flush();
      test_async_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d results never produced, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_access_queue.md
MEM_ACCESS_QUEUE -- requirements
Module: mem_access_queue

Interface
REQ-001 SHALL have port clk input 1: single system clock; all state updates on posedge.
REQ-002 SHALL have port rst input 1: asynchronous, active-low reset.
REQ-003 SHALL have ports flush and freeze_back, each input 1: pipeline flush and back-end stall.
REQ-004 SHALL have port valid_Addr_agu input 1: an address from the address stage is valid this cycle.
REQ-005 SHALL have port Addr_agu input 16: effective address.
REQ-006 SHALL have ports tag_ROB_Result_agu input 5, is_store_agu input 1 and data_store_agu input 16: ROB tag, store flag and store data.
REQ-007 SHALL have port full_lsq output 1: the queue holds 4 entries, so upstream must not present valid.
REQ-008 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output 16 and mem_wdata output 16: data-memory request.
REQ-009 SHALL have ports mem_ack input 1 and mem_rdata input 16: memory accept and load data, sampled in the same cycle as mem_ack.
REQ-010 SHALL have ports valid_Result_mem output 1, tag_ROB_Result_mem output 5 and Result_mem output 16: completion broadcast.

Function
REQ-011 SHALL hold a 4-entry in-order FIFO of {addr, tag, is_store, wdata}, using 2-bit read and write pointers plus a wrap bit.
REQ-012 SHALL enqueue at posedge when valid_Addr_agu && !full_lsq && !flush && !freeze_back.
REQ-013 SHALL ignore valid_Addr_agu while full_lsq is high, with no state change; the bench flags this as a protocol error.
REQ-014 SHALL drive full_lsq combinationally from the pointers, asserting it when the write and read indices are equal and the wrap bits differ.
REQ-015 SHALL use the FSM states IDLE, REQ and DONE.
REQ-016 IDLE SHALL go to REQ when the FIFO is non-empty at the clock edge, and SHALL otherwise stay in IDLE.
REQ-017 In REQ, the block SHALL assert mem_req with mem_addr, mem_we and mem_wdata taken from the head entry, and these outputs SHALL be derived combinationally from the state and head.
REQ-018 In REQ with mem_ack high, the block SHALL pop the head, load the result registers and go to DONE; without mem_ack it SHALL stay in REQ and hold the request stable.
REQ-019 The result registers SHALL be loaded as tag_ROB_Result_mem = head tag, and Result_mem = mem_rdata for a load or 16'h0000 for a store.
REQ-020 valid_Result_mem SHALL be high exactly while the FSM is in DONE.
REQ-021 DONE SHALL hold while freeze_back is high, with the result registers unchanged; otherwise it SHALL go to REQ if the FIFO is non-empty, else to IDLE.
REQ-022 Minimum latency SHALL be: enqueue edge E0, mem_req high in the cycle after E1, and valid_Result_mem high after E2 when mem_ack arrives the same cycle.
REQ-023 freeze_back SHALL block enqueue and hold DONE, but SHALL NOT block an in-flight REQ/ack handshake.
REQ-024 flush SHALL take priority over every other input: at the edge it empties the FIFO, sends the FSM to IDLE and clears the result registers.
REQ-025 A handshake completing in a flush cycle SHALL be discarded, with no result produced; the ROB guarantees that such a store was not yet committable.
REQ-026 A simultaneous enqueue and pop SHALL keep the count unchanged, and the pointers SHALL wrap modulo 4.

Reset
REQ-027 When rst is low, the block SHALL asynchronously clear the pointers, wrap bits and FIFO valid state, set the FSM to IDLE, and set valid_Result_mem, tag_ROB_Result_mem and Result_mem to 0.
REQ-028 After reset, full_lsq, mem_req, mem_we, mem_addr and mem_wdata SHALL all read 0.
REQ-029 Assertion of rst mid-transaction SHALL abandon the transaction immediately, with mem_req dropping asynchronously.

Structure
REQ-030 A shared package SHALL hold the data width (16), the tag width (5), the queue depth (4), the FSM state enum and the entry struct.
REQ-031 A single sub-module, lsq_fifo, holding the storage and pointers, SHALL be instantiated once; the FSM and result registers SHALL live in the top module.

Verification
REQ-032 Single load, addr 16'h0040, tag 5'd3, mem_ack immediate, rdata 16'hBEEF: valid_Result_mem SHALL pulse for one cycle two cycles after the enqueue edge, with tag 3 and data BEEF.
REQ-033 Four back-to-back loads with mem_ack held low: full_lsq SHALL assert after the fourth enqueue, and a fifth valid SHALL be ignored.
REQ-034 Store, addr 16'h0010, data 16'h1234, with mem_ack delayed 3 cycles: mem_req and mem_we SHALL stay stable for 3 cycles, then the result SHALL report data 0.
REQ-035 Flush while in REQ with 3 entries queued: the next cycle SHALL show mem_req 0, FIFO empty and no result.
REQ-036 freeze_back held 2 cycles while in DONE: valid_Result_mem and the tag SHALL hold, and enqueue SHALL be blocked.
REQ-037 rst pulsed low mid-REQ: all outputs SHALL be 0 without waiting for a clock edge.
